// File: rtl/cxl2_cache_d2h_req_responder.sv
// Host-side CXL.cache D2H request responder: answers device requests with GO-family
// responses, tracks write-pull UQIDs and issues ExtCmp for weakly-ordered writes.
module cxl2_cache_d2h_req_responder #(
    parameter int NUM_UQID = 16,
    parameter int UQID_W   = $clog2(NUM_UQID)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d2h_req_valid,
    output logic              d2h_req_ready,
    input  logic [4:0]        d2h_req_opcode,
    input  logic [11:0]       d2h_req_cqid,
    input  logic              d2h_req_nt,
    output logic              h2d_rsp_valid,
    input  logic              h2d_rsp_ready,
    output logic [3:0]        h2d_rsp_opcode,
    output logic [11:0]       h2d_rsp_data,
    output logic [1:0]        h2d_rsp_pre,
    output logic [11:0]       h2d_rsp_cqid,
    input  logic              d2h_data_valid,
    input  logic [11:0]       d2h_data_uqid,
    input  logic              d2h_data_bogus,
    input  logic              d2h_data_poison,
    output logic              wr_done_valid,
    output logic [11:0]       wr_done_uqid,
    output logic              wr_done_bogus,
    output logic              wr_done_poison,
    output logic              err_unexp_data,
    output logic [UQID_W:0]   outstanding_cnt
);

    localparam logic [4:0] RDCURR           = 5'b00001;
    localparam logic [4:0] RDOWN            = 5'b00010;
    localparam logic [4:0] RDSHARED         = 5'b00011;
    localparam logic [4:0] RDANY            = 5'b00100;
    localparam logic [4:0] RDOWNNODATA      = 5'b00101;
    localparam logic [4:0] ITOMWR           = 5'b00110;
    localparam logic [4:0] MEMWR            = 5'b00111;
    localparam logic [4:0] CLFLUSH          = 5'b01000;
    localparam logic [4:0] CLEANEVICT       = 5'b01001;
    localparam logic [4:0] DIRTYEVICT       = 5'b01010;
    localparam logic [4:0] CLEANEVICTNODATA = 5'b01011;
    localparam logic [4:0] WOWRINV          = 5'b01100;
    localparam logic [4:0] WOWRINVF         = 5'b01101;
    localparam logic [4:0] WRINV            = 5'b01110;
    localparam logic [4:0] CACHEFLUSHED     = 5'b10000;

    localparam logic [3:0] RSP_GO          = 4'b0100;
    localparam logic [3:0] RSP_GO_WP       = 4'b0101;
    localparam logic [3:0] RSP_EXTCMP      = 4'b0110;
    localparam logic [3:0] RSP_FASTGO_WP   = 4'b1101;

    logic [NUM_UQID-1:0] trk_valid;
    logic [NUM_UQID-1:0] trk_wo;
    logic [11:0]         trk_cqid [NUM_UQID];

    logic [11:0]         ext_mem [NUM_UQID];
    logic [UQID_W-1:0]   ext_rd;
    logic [UQID_W-1:0]   ext_wr;
    logic [UQID_W:0]     ext_cnt;

    logic              out_free;
    logic              ext_empty;
    logic              req_fire;
    logic              alloc;
    logic [UQID_W-1:0] alloc_idx;
    logic [UQID_W-1:0] data_idx;
    logic              data_hit;
    logic              ext_push;
    logic              ext_pop;
    logic [3:0]        dec_op;
    logic [3:0]        dec_state;
    logic              dec_wp;
    logic              dec_wo;
    logic              unused_nt;

    assign unused_nt = d2h_req_nt;
    assign h2d_rsp_pre = 2'b00;

    // Valid/ready: a transfer happens on any cycle where both are high. The request
    // side stalls whenever the response register cannot take a new entry, an ExtCmp
    // is waiting, or every UQID is in use, independent of the offered opcode.
    assign out_free      = !h2d_rsp_valid || h2d_rsp_ready;
    assign ext_empty     = (ext_cnt == '0);
    assign d2h_req_ready = out_free && ext_empty && !(&trk_valid);
    assign req_fire      = d2h_req_valid && d2h_req_ready;
    assign alloc         = req_fire && dec_wp;
    assign ext_pop       = out_free && !ext_empty;

    assign data_idx = d2h_data_uqid[UQID_W-1:0];
    assign data_hit = d2h_data_valid && (d2h_data_uqid[11:UQID_W] == '0) && trk_valid[data_idx];
    assign ext_push = data_hit && trk_wo[data_idx];

    always_comb begin
        dec_op    = RSP_GO;
        dec_state = 4'b0100;
        dec_wp    = 1'b0;
        dec_wo    = 1'b0;
        case (d2h_req_opcode)
            RDCURR:                                  dec_state = 4'b0011;
            RDSHARED:                                dec_state = 4'b0001;
            RDOWN, RDANY, RDOWNNODATA:               dec_state = 4'b0010;
            CLFLUSH, CLEANEVICTNODATA, CACHEFLUSHED: dec_state = 4'b0011;
            CLEANEVICT, DIRTYEVICT, ITOMWR, MEMWR: begin
                dec_op = RSP_GO_WP;
                dec_wp = 1'b1;
            end
            WOWRINV, WOWRINVF, WRINV: begin
                dec_op = RSP_FASTGO_WP;
                dec_wp = 1'b1;
                dec_wo = 1'b1;
            end
            default: ;
        endcase
    end

    // Lowest-index free entry; scanning downward lets the lowest index win.
    always_comb begin
        alloc_idx = '0;
        for (int i = NUM_UQID - 1; i >= 0; i--) begin
            if (!trk_valid[i]) alloc_idx = UQID_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h2d_rsp_valid  <= 1'b0;
            h2d_rsp_opcode <= '0;
            h2d_rsp_data   <= '0;
            h2d_rsp_cqid   <= '0;
        end else if (out_free) begin
            if (!ext_empty) begin
                h2d_rsp_valid  <= 1'b1;
                h2d_rsp_opcode <= RSP_EXTCMP;
                h2d_rsp_data   <= '0;
                h2d_rsp_cqid   <= ext_mem[ext_rd];
            end else if (req_fire) begin
                h2d_rsp_valid  <= 1'b1;
                h2d_rsp_opcode <= dec_op;
                h2d_rsp_data   <= dec_wp ? {{(12-UQID_W){1'b0}}, alloc_idx} : {8'h00, dec_state};
                h2d_rsp_cqid   <= d2h_req_cqid;
            end else begin
                h2d_rsp_valid  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_valid       <= '0;
            trk_wo          <= '0;
            outstanding_cnt <= '0;
        end else begin
            if (data_hit) trk_valid[data_idx] <= 1'b0;
            if (alloc) begin
                trk_valid[alloc_idx] <= 1'b1;
                trk_wo[alloc_idx]    <= dec_wo;
            end
            if (alloc && !data_hit)
                outstanding_cnt <= outstanding_cnt + (UQID_W+1)'(1);
            else if (!alloc && data_hit)
                outstanding_cnt <= outstanding_cnt - (UQID_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) trk_cqid[alloc_idx] <= d2h_req_cqid;
        if (ext_push) ext_mem[ext_wr] <= trk_cqid[data_idx];
    end

    // ExtCmp FIFO holds at most one entry per UQID, so it never overflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_rd  <= '0;
            ext_wr  <= '0;
            ext_cnt <= '0;
        end else begin
            if (ext_push) ext_wr <= ext_wr + UQID_W'(1);
            if (ext_pop)  ext_rd <= ext_rd + UQID_W'(1);
            if (ext_push && !ext_pop)
                ext_cnt <= ext_cnt + (UQID_W+1)'(1);
            else if (!ext_push && ext_pop)
                ext_cnt <= ext_cnt - (UQID_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_done_valid  <= 1'b0;
            wr_done_uqid   <= '0;
            wr_done_bogus  <= 1'b0;
            wr_done_poison <= 1'b0;
            err_unexp_data <= 1'b0;
        end else begin
            wr_done_valid  <= data_hit;
            wr_done_uqid   <= d2h_data_uqid;
            wr_done_bogus  <= d2h_data_bogus;
            wr_done_poison <= d2h_data_poison;
            err_unexp_data <= d2h_data_valid && !data_hit;
        end
    end

endmodule
